// File: rtl/nts_api_pkg.sv
// Shared definitions for the NTS API arbiter: FSM state encoding and
// READ_LATENCY legal bounds.
package nts_api_pkg;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 15;
  localparam int unsigned LAT_CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } api_state_t;

  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/nts_rr_arbiter2.sv
// Two-way round-robin picker; the pointer remembers the last granted
// requester and is advanced only when the update enable is high.
module nts_rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_areset_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  logic last_q;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = last_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer starts at 1 so requester 0 takes the first tie.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      last_q <= 1'b1;
    end else if (i_update && (|i_req)) begin
      last_q <= o_grant[1];
    end
  end

endmodule

// File: rtl/nts_api_arbiter.sv
// Round-robin arbiter sharing one API bus between host and sequencer.
// Optional statistics counters are enabled with NTS_API_ARBITER_STATS_EN.
module nts_api_arbiter
  import nts_api_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic        i_req0_cs,
  input  logic        i_req0_we,
  input  logic [11:0] i_req0_address,
  input  logic [31:0] i_req0_write_data,
  output logic        o_req0_ack,
  output logic [31:0] o_req0_read_data,
  input  logic        i_req1_cs,
  input  logic        i_req1_we,
  input  logic [11:0] i_req1_address,
  input  logic [31:0] i_req1_write_data,
  output logic        o_req1_ack,
  output logic [31:0] o_req1_read_data,
  output logic        o_api_cs,
  output logic        o_api_we,
  output logic [11:0] o_api_address,
  output logic [31:0] o_api_write_data,
  input  logic [31:0] i_api_read_data
`ifdef NTS_API_ARBITER_STATS_EN
  ,
  output logic [31:0] o_stat_grants0,
  output logic [31:0] o_stat_grants1,
  output logic [31:0] o_stat_conflicts
`endif
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_lat_range
    $error("nts_api_arbiter: READ_LATENCY out of range");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LATENCY - 1);

  api_state_t           state_q, state_d;
  logic [1:0]           req;
  logic [1:0]           grant;
  logic                 pick;
  logic                 capture;
  logic                 win_q;
  logic                 we_q;
  logic [11:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [LAT_CNT_W-1:0] cnt_q;
  logic [31:0]          rd0_q, rd1_q;

  assign req     = {i_req1_cs, i_req0_cs};
  assign pick    = (state_q == ST_IDLE);
  assign capture = (state_q == ST_WAIT) && (cnt_q == LAT_LAST);

  nts_rr_arbiter2 u_rr (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_req      (req),
    .i_update   (pick),
    .o_grant    (grant)
  );

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (capture) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Fields are latched once at grant; later requester changes are ignored.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      if (pick && (|req)) begin
        win_q   <= grant[1];
        we_q    <= grant[1] ? i_req1_we         : i_req0_we;
        addr_q  <= grant[1] ? i_req1_address    : i_req0_address;
        wdata_q <= grant[1] ? i_req1_write_data : i_req0_write_data;
      end
      if (state_q == ST_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + LAT_CNT_W'(1);
      end
      if (capture) begin
        if (win_q) rd1_q <= i_api_read_data;
        else       rd0_q <= i_api_read_data;
      end
    end
  end

  assign o_api_cs         = (state_q == ST_ISSUE);
  assign o_api_we         = o_api_cs & we_q;
  assign o_api_address    = o_api_cs ? addr_q  : '0;
  assign o_api_write_data = o_api_cs ? wdata_q : '0;

  assign o_req0_ack       = (state_q == ST_DONE) & ~win_q;
  assign o_req1_ack       = (state_q == ST_DONE) &  win_q;
  assign o_req0_read_data = rd0_q;
  assign o_req1_read_data = rd1_q;

`ifdef NTS_API_ARBITER_STATS_EN
  logic [31:0] grants0_q, grants1_q, conflicts_q;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      grants0_q   <= '0;
      grants1_q   <= '0;
      conflicts_q <= '0;
    end else if (pick) begin
      if (grant[0] && (grants0_q != '1)) grants0_q <= grants0_q + 32'd1;
      if (grant[1] && (grants1_q != '1)) grants1_q <= grants1_q + 32'd1;
      if ((req == 2'b11) && (conflicts_q != '1)) conflicts_q <= conflicts_q + 32'd1;
    end
  end

  assign o_stat_grants0   = grants0_q;
  assign o_stat_grants1   = grants1_q;
  assign o_stat_conflicts = conflicts_q;
`endif

endmodule
